gon_tx_ctrl: RTL
================

// Module: gon_tx_ctrl
// PURPOSE
//  Transmit end of the Global-On-Chip Network (GON): sits between the global buffer and the
//  row/column multicast controllers (MCCs). Buffers a tagged data stream, drives bus data,
//  row/col tags and enable, and completes a transfer only when every row returns ready.
//  Sends a programmed number of transfers per job, then pulses done.
// PARAMETERS
//  DATA_WIDTH  64  bus payload width
//  TAG_WIDTH   4   row/col tag width; matches the MCC scan-ID width
//  NUM_ROWS    12  number of row MCC ready lines reduced by this block
//  FIFO_DEPTH  4   input buffer entries; power of 2, >=2
//  CNT_WIDTH   16  width of the job transfer counter
// PORTS
//  clk          in   1            clock, rising edge
//  reset        in   1            asynchronous, active-low reset
//  start        in   1            job start pulse; sampled in IDLE only
//  num_xfers    in   CNT_WIDTH    transfers in the job; sampled with start
//  busy         out  1            high in RUN and DONE
//  done         out  1            one-cycle pulse at job end
//  xfer_count   out  CNT_WIDTH    completed bus transfers in the current job
//  in_valid     in   1            GLB word valid
//  in_data      in   DATA_WIDTH   GLB payload
//  in_row_tag   in   TAG_WIDTH    destination row tag
//  in_col_tag   in   TAG_WIDTH    destination column tag
//  in_ready     out  1            this block accepts the word this cycle
//  bus_data     out  DATA_WIDTH   GON payload
//  bus_row_tag  out  TAG_WIDTH    GON row tag
//  bus_col_tag  out  TAG_WIDTH    GON column tag
//  bus_enable   out  1            GON enable, to all row MCCs
//  bus_ready    in   NUM_ROWS     per-row ready from the row MCCs
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, FIFO empty, counters 0. All outputs 0, including in_ready.
//  FSM: IDLE -start&num_xfers!=0-> RUN.
//   IDLE -start&num_xfers==0-> DONE (no bus activity).
//   RUN -last transfer completes-> DONE. DONE -> IDLE after one cycle.
//  done=1 only in DONE. start is ignored outside IDLE.
//  Accept count: in_ready = RUN & !full & (accepted < num_xfers). Push on in_valid&in_ready.
//   Words beyond num_xfers are never accepted.
//  Bus: bus_enable = RUN & !empty. bus_data/tags = FIFO head while enable=1, else all 0.
//  Transfer completes in a cycle with bus_enable & (&bus_ready). That cycle pops the head,
//   and xfer_count increments at the following edge.
//  bus_ready is ignored while bus_enable=0.
//  Hold rule: while bus_enable=1 and any bus_ready bit is 0, bus_data, tags and enable stay
//   stable. No retraction and no head change.
//  Latency: a word pushed at edge N is visible on the bus in cycle N+1 at the earliest. There
//   is no same-cycle bypass, including when the FIFO is empty.
//  Throughput: 1 transfer/cycle when bus_ready stays all-ones.
//  Simultaneous push+pop is allowed when not full. When full, in_ready=0 even if a pop
//   occurs that cycle.
//  FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. full/empty are derived
//   from an occupancy counter of log2(FIFO_DEPTH)+1 bits.
//  Last transfer: xfer_count==num_xfers-1 with a completing transfer -> DONE next cycle.
//   xfer_count holds its final value through DONE and clears on the next accepted start.
//   It never wraps.
//  Reset mid-job: the job is aborted, the FIFO is flushed, no done pulse is generated, and
//   bus_enable drops asynchronously.
// TESTING
//  1 reset low mid-RUN with 2 words buffered -> all outputs 0 at once; after release FSM
//    is IDLE, and a new start sends fresh data only.
//  2 start, num_xfers=3; 3 words, tags (r1,c2), bus_ready all-ones -> bus_enable high for 3
//    consecutive cycles, first beat 1 cycle after first push; done pulses; xfer_count=3.
//  3 num_xfers=1, bus_ready[5]=0 for 4 cycles -> bus_data/tags/enable held constant for 4
//    cycles; transfer completes when bit 5 rises; done the next cycle.
//  4 FIFO_DEPTH=4, bus_ready=0, 6 words offered, num_xfers=6 -> in_ready drops after 4
//    pushes; release ready -> all 6 sent in order; no loss or duplication.
//  5 start with num_xfers=0 -> done pulses 1 cycle after start; in_ready and bus_enable
//    never assert.
//  6 num_xfers=2, GLB offers 3 words -> the 3rd is never accepted; start during RUN is
//    ignored.

Source files
------------

// File: rtl/gon_tx_ctrl_if.sv
// GON transmit-side bus bundle: GLB input stream plus the multicast bus to the row MCCs.
// Latency: none (wiring only).
// Backpressure: in_ready stalls the GLB stream; bus_ready (one bit per row) stalls the bus.
interface gon_tx_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4,
    parameter int NUM_ROWS   = 12
);
    // GLB side
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [TAG_WIDTH-1:0]  in_row_tag;
    logic [TAG_WIDTH-1:0]  in_col_tag;
    logic                  in_ready;

    // GON bus side
    logic [DATA_WIDTH-1:0] bus_data;
    logic [TAG_WIDTH-1:0]  bus_row_tag;
    logic [TAG_WIDTH-1:0]  bus_col_tag;
    logic                  bus_enable;
    logic [NUM_ROWS-1:0]   bus_ready;

    // Environment view: the GLB producer together with the row MCC consumers.
    modport master (
        output in_valid, in_data, in_row_tag, in_col_tag, bus_ready,
        input  in_ready, bus_data, bus_row_tag, bus_col_tag, bus_enable
    );

    // Transmit controller view.
    modport slave (
        input  in_valid, in_data, in_row_tag, in_col_tag, bus_ready,
        output in_ready, bus_data, bus_row_tag, bus_col_tag, bus_enable
    );
endinterface

// File: rtl/gon_tx_ctrl.sv
// GON transmit controller: buffers tagged GLB words and multicasts a job's worth onto the bus.
// Latency: a word pushed at edge N reaches the bus in cycle N+1 at the earliest (no bypass).
// Backpressure: bus holds until every row is ready; in_ready drops when full or job quota met.
module gon_tx_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4,
    parameter int NUM_ROWS   = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_xfers,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] xfer_count,
    gon_tx_ctrl_if.slave         gif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  row_tag;
        logic [TAG_WIDTH-1:0]  col_tag;
    } entry_t;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       occ_q, occ_d;
    entry_t               mem_q [FIFO_DEPTH];
    entry_t               mem_d [FIFO_DEPTH];

    entry_t head;
    entry_t in_entry;
    logic   run;
    logic   full;
    logic   empty;
    logic   in_rdy;
    logic   bus_en;
    logic   push;
    logic   pop;
    logic   last;

    // Handshake qualifiers; a full FIFO refuses input even if the head pops this cycle.
    always_comb begin
        run      = (state_q == S_RUN);
        full     = (occ_q == DEPTH_C);
        empty    = (occ_q == '0);
        in_rdy   = run && !full && (acc_q < num_q);
        push     = gif.in_valid && in_rdy;
        bus_en   = run && !empty;
        pop      = bus_en && (&gif.bus_ready);
        last     = (xfer_q == num_q - CNT_WIDTH'(1));
        head     = mem_q[rd_ptr_q];
        in_entry = '{data: gif.in_data, row_tag: gif.in_row_tag, col_tag: gif.in_col_tag};
    end

    // Bus and status outputs; payload is zeroed whenever the bus is idle.
    always_comb begin
        gif.in_ready    = in_rdy;
        gif.bus_enable  = bus_en;
        gif.bus_data    = bus_en ? head.data    : '0;
        gif.bus_row_tag = bus_en ? head.row_tag : '0;
        gif.bus_col_tag = bus_en ? head.col_tag : '0;
        busy            = (state_q == S_RUN) || (state_q == S_DONE);
        done            = (state_q == S_DONE);
        xfer_count      = xfer_q;
    end

    // FIFO storage and pointer/occupancy update.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Job FSM: counts accepted words and completed transfers against the latched job size.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        acc_d   = acc_q;
        xfer_d  = xfer_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_xfers;
                    acc_d   = '0;
                    xfer_d  = '0;
                    state_d = (num_xfers == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    acc_d = acc_q + CNT_WIDTH'(1);
                end
                if (pop) begin
                    xfer_d = xfer_q + CNT_WIDTH'(1);
                    if (last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any job and flushes the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            acc_q    <= '0;
            xfer_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            acc_q    <= acc_d;
            xfer_q   <= xfer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            mem_q    <= mem_d;
        end
    end

endmodule
